pc_unit: RTL and testbench

Parametrised program-counter unit for the pipelined datapath; it replaces the single-register PC in front of instruction memory. It holds the fetch address and advances it by a fixed increment. It also redirects on trap, jump or branch, freezes on a pipeline stall, and holds a redirect that arrives during a stall until the stall releases. It records the exception PC and counts PC advances for the performance counters.

---
 rtl/pc_unit.sv | 127 ++++++++++++
 tb/tb_pc_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address, applies trap/jump/branch redirects,
// defers redirects that arrive during a stall, records the trap PC and counts PC advances.
module pc_unit #(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0]  TRAP_VECTOR  = 32'h0000_0080,
    parameter int                INCR         = 4,
    parameter int                CNT_WIDTH    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 trap_i,
    input  logic                 jump_i,
    input  logic [WIDTH-1:0]     jump_target_i,
    input  logic                 branch_taken_i,
    input  logic [WIDTH-1:0]     branch_target_i,
    output logic [WIDTH-1:0]     pc_result_o,
    output logic [WIDTH-1:0]     pc_plus4_o,
    output logic [WIDTH-1:0]     epc_o,
    output logic                 redirect_pending_o,
    output logic                 misaligned_o,
    output logic [CNT_WIDTH-1:0] advance_count_o
);

    localparam logic [WIDTH-1:0]     INCR_W  = WIDTH'(INCR);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);

    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [WIDTH-1:0]     epc_q, epc_d;
    logic                 pend_q, pend_d;
    logic [WIDTH-1:0]     pend_tgt_q, pend_tgt_d;
    logic                 mis_q, mis_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 redirect_s;
    logic [WIDTH-1:0]     sel_target_s;
    logic [WIDTH-1:0]     aligned_target_s;
    logic                 advance_s;

    // Select the incoming redirect target; jump has priority over branch.
    always_comb begin
        redirect_s       = jump_i | branch_taken_i;
        sel_target_s     = branch_target_i;
        if (jump_i) begin
            sel_target_s = jump_target_i;
        end else begin
            sel_target_s = branch_target_i;
        end
        aligned_target_s = {sel_target_s[WIDTH-1:2], 2'b00};
    end

    // Next-state logic in priority order: trap, new redirect, held redirect, stall, increment.
    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        advance_s  = 1'b0;
        if (trap_i) begin
            pc_d       = TRAP_VECTOR;
            epc_d      = pc_q;
            pend_d     = 1'b0;
            pend_tgt_d = '0;
            advance_s  = 1'b1;
        end else if (redirect_s && !stall_i) begin
            // A fresh redirect supersedes anything still held from a stall.
            pc_d      = aligned_target_s;
            pend_d    = 1'b0;
            advance_s = 1'b1;
        end else if (redirect_s) begin
            pend_d     = 1'b1;
            pend_tgt_d = aligned_target_s;
        end else if (pend_q && !stall_i) begin
            pc_d      = pend_tgt_q;
            pend_d    = 1'b0;
            advance_s = 1'b1;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else begin
            pc_d      = pc_q + INCR_W;
            advance_s = 1'b1;
        end
    end

    // Misalignment flag and advance counter next state.
    always_comb begin
        mis_d = 1'b0;
        if (!trap_i && redirect_s && (sel_target_s[1:0] != 2'b00)) begin
            mis_d = 1'b1;
        end else begin
            mis_d = 1'b0;
        end
        if (advance_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            mis_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            mis_q      <= mis_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc_result_o        = pc_q;
    assign pc_plus4_o         = pc_q + INCR_W;
    assign epc_o              = epc_q;
    assign redirect_pending_o = pend_q;
    assign misaligned_o       = mis_q;
    assign advance_count_o    = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with fixed expectations,
// then randomized control traffic against a behavioural reference model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0, stall = 1'b0, trap = 1'b0, jump = 1'b0, branch = 1'b0;
    logic [31:0] jt = 32'h0, bt = 32'h0;
    logic [31:0] pc, pcp4, epc, cnt;
    logic        pend, mis;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc = 32'h0, m_epc = 32'h0, m_ptgt = 32'h0, m_cnt = 32'h0;
    bit          m_pend = 1'b0, m_mis = 1'b0;

    pc_unit dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .stall_i            (stall),
        .trap_i             (trap),
        .jump_i             (jump),
        .jump_target_i      (jt),
        .branch_taken_i     (branch),
        .branch_target_i    (bt),
        .pc_result_o        (pc),
        .pc_plus4_o         (pcp4),
        .epc_o              (epc),
        .redirect_pending_o (pend),
        .misaligned_o       (mis),
        .advance_count_o    (cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model of one clock edge, written from the operating rules.
    task automatic model_step();
        logic [31:0] tgt;
        bit          want_redirect;
        if (rst) begin
            m_pc = 32'h0; m_epc = 32'h0; m_pend = 0; m_ptgt = 32'h0; m_mis = 0; m_cnt = 32'h0;
        end else begin
            want_redirect = jump || branch;
            tgt   = jump ? jt : bt;
            m_mis = !trap && want_redirect && (tgt % 4 != 0);
            tgt   = tgt - (tgt % 4);
            if (trap) begin
                m_epc = m_pc; m_pc = 32'h80; m_pend = 0; m_cnt = m_cnt + 1;
            end else if (want_redirect && !stall) begin
                m_pc = tgt; m_pend = 0; m_cnt = m_cnt + 1;
            end else if (want_redirect) begin
                m_pend = 1; m_ptgt = tgt;
            end else if (m_pend && !stall) begin
                m_pc = m_ptgt; m_pend = 0; m_cnt = m_cnt + 1;
            end else if (!stall) begin
                m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000); m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic cycle(input logic r, input logic t, input logic s,
                         input logic j, input logic [31:0] jtv,
                         input logic b, input logic [31:0] btv);
        rst = r; trap = t; stall = s; jump = j; jt = jtv; branch = b; bt = btv;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 32'h0, 0, 32'h0);
        cycle(1, 1, 0, 0, 32'h0, 0, 32'h0);
        n_checks++; if (pc !== 32'h0)  begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got=%h exp=%h", epc, 32'h0); end
        n_checks++; if (pend !== 1'b0) begin n_fail++; $display("FAIL reset_pend got=%b exp=0", pend); end
        n_checks++; if (mis !== 1'b0)  begin n_fail++; $display("FAIL reset_mis got=%b exp=0", mis); end
        n_checks++; if (cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    endtask

    task automatic test_run();
        logic [31:0] exp_seq [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 32'h0, 0, 32'h0);
            n_checks++;
            if (pc !== exp_seq[i]) begin n_fail++; $display("FAIL run_pc[%0d] got=%h exp=%h", i, pc, exp_seq[i]); end
        end
        n_checks++; if (pcp4 !== 32'h14) begin n_fail++; $display("FAIL run_pcplus4 got=%h exp=%h", pcp4, 32'h14); end
        n_checks++; if (cnt !== 32'd4)   begin n_fail++; $display("FAIL run_cnt got=%0d exp=4", cnt); end
    endtask

    task automatic test_branch();
        cycle(0, 0, 0, 0, 32'h0, 1, 32'h200);
        n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL branch_pc got=%h exp=%h", pc, 32'h200); end
        n_checks++; if (cnt !== 32'd5)  begin n_fail++; $display("FAIL branch_cnt got=%0d exp=5", cnt); end
        cycle(0, 0, 0, 0, 32'h0, 0, 32'h0);
        n_checks++; if (pc !== 32'h204) begin n_fail++; $display("FAIL branch_next got=%h exp=%h", pc, 32'h204); end
        cycle(0, 0, 0, 1, 32'h300, 1, 32'h400);
        n_checks++; if (pc !== 32'h300) begin n_fail++; $display("FAIL jump_beats_branch got=%h exp=%h", pc, 32'h300); end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] c0;
        cycle(0, 0, 0, 1, 32'h20, 0, 32'h0);
        c0 = cnt;
        cycle(0, 0, 1, 0, 32'h0, 1, 32'h100);
        n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL stall_hold_pc got=%h exp=%h", pc, 32'h20); end
        n_checks++; if (pend !== 1'b1) begin n_fail++; $display("FAIL stall_pend_set got=%b exp=1", pend); end
        cycle(0, 0, 1, 0, 32'h0, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'h0, 0, 32'h0);
        n_checks++; if (pc !== 32'h20 || pend !== 1'b1) begin n_fail++; $display("FAIL stall_hold3 got pc=%h pend=%b exp pc=%h pend=1", pc, pend, 32'h20); end
        cycle(0, 0, 0, 0, 32'h0, 0, 32'h0);
        n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL stall_release_pc got=%h exp=%h", pc, 32'h100); end
        n_checks++; if (pend !== 1'b0)  begin n_fail++; $display("FAIL stall_release_pend got=%b exp=0", pend); end
        n_checks++; if (cnt !== c0 + 32'd1) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=%0d", cnt, c0 + 32'd1); end
    endtask

    task automatic test_trap();
        cycle(0, 0, 0, 1, 32'h44, 0, 32'h0);
        cycle(0, 0, 1, 0, 32'h0, 1, 32'h500);
        cycle(0, 1, 1, 0, 32'h0, 0, 32'h0);
        n_checks++; if (pc !== 32'h80)  begin n_fail++; $display("FAIL trap_pc got=%h exp=%h", pc, 32'h80); end
        n_checks++; if (epc !== 32'h44) begin n_fail++; $display("FAIL trap_epc got=%h exp=%h", epc, 32'h44); end
        n_checks++; if (pend !== 1'b0)  begin n_fail++; $display("FAIL trap_pend got=%b exp=0", pend); end
        cycle(0, 0, 1, 0, 32'h0, 0, 32'h0);
        cycle(0, 0, 0, 0, 32'h0, 0, 32'h0);
        n_checks++; if (pc !== 32'h84) begin n_fail++; $display("FAIL trap_no_stale got=%h exp=%h", pc, 32'h84); end
    endtask

    task automatic test_wrap_align();
        cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        n_checks++; if (pcp4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pcplus4 got=%h exp=%h", pcp4, 32'h0); end
        cycle(0, 0, 0, 0, 32'h0, 0, 32'h0);
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
        cycle(0, 0, 0, 1, 32'h103, 0, 32'h0);
        n_checks++; if (pc !== 32'h100 || mis !== 1'b1) begin n_fail++; $display("FAIL align_jump got pc=%h mis=%b exp pc=%h mis=1", pc, mis, 32'h100); end
        cycle(0, 0, 0, 0, 32'h0, 0, 32'h0);
        n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL align_pulse got=%b exp=0", mis); end
        cycle(0, 0, 1, 0, 32'h0, 1, 32'h202);
        n_checks++; if (mis !== 1'b1 || pend !== 1'b1) begin n_fail++; $display("FAIL align_held got mis=%b pend=%b exp 1 1", mis, pend); end
        cycle(0, 0, 0, 0, 32'h0, 0, 32'h0);
        n_checks++; if (pc !== 32'h200 || mis !== 1'b0) begin n_fail++; $display("FAIL align_release got pc=%h mis=%b exp pc=%h mis=0", pc, mis, 32'h200); end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 0, 0, 32'h0, 0, 32'h0);
        cycle(0, 0, 1, 1, 32'h700, 0, 32'h0);
        cycle(1, 1, 1, 0, 32'h0, 0, 32'h0);
        n_checks++; if (pc !== 32'h0 || pend !== 1'b0) begin n_fail++; $display("FAIL rstmid_pc got pc=%h pend=%b exp 0 0", pc, pend); end
        n_checks++; if (cnt !== 32'h0 || epc !== 32'h0) begin n_fail++; $display("FAIL rstmid_cnt_epc got cnt=%0d epc=%h exp 0 0", cnt, epc); end
        cycle(0, 0, 0, 0, 32'h0, 0, 32'h0);
        n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL rstmid_lost got=%h exp=%h", pc, 32'h4); end
    endtask

    task automatic test_random();
        logic [31:0] rjt, rbt;
        for (int i = 0; i < 3000; i++) begin
            rjt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            rbt = $urandom;
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0, rjt, $urandom_range(0, 4) == 0, rbt);
            n_checks++;
            if (pc !== m_pc || pcp4 !== m_pc + 32'd4 || epc !== m_epc || pend !== m_pend ||
                mis !== m_mis || cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL random[%0d] got pc=%h p4=%h epc=%h pend=%b mis=%b cnt=%0d exp pc=%h p4=%h epc=%h pend=%b mis=%b cnt=%0d",
                         i, pc, pcp4, epc, pend, mis, cnt, m_pc, m_pc + 32'd4, m_epc, m_pend, m_mis, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_branch();
        test_stall_redirect();
        test_trap();
        test_wrap_align();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
